// File: rtl/lpif_txrx_x8_asym1_full_slave_link.sv
// Slave-end LPIF x8 asym1 full-rate link adapter: unpacks RX FIFO words onto dstrm_* through a
// 2-entry skid and packs ustrm_* events into TX FIFO words through a second 2-entry skid.
module lpif_txrx_x8_asym1_full_slave_link #(
  parameter int DATA_WIDTH = 256,
  parameter int CRC_WIDTH  = 8,
  parameter int GEN1_WIDTH = 128,
  parameter int WORD_WIDTH = 4 + 2 + DATA_WIDTH + 1 + CRC_WIDTH + 1 + 1
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr_n,
  input  logic                  m_gen2_mode,
  input  logic [WORD_WIDTH-1:0] rxfifo_downstream_data,
  input  logic                  rxfifo_downstream_vld,
  output logic                  rxfifo_downstream_rd,
  output logic [3:0]            dstrm_state,
  output logic [1:0]            dstrm_protid,
  output logic [DATA_WIDTH-1:0] dstrm_data,
  output logic                  dstrm_dvalid,
  output logic [CRC_WIDTH-1:0]  dstrm_crc,
  output logic                  dstrm_crc_valid,
  output logic                  dstrm_valid,
  input  logic                  dstrm_ready,
  input  logic [3:0]            ustrm_state,
  input  logic [1:0]            ustrm_protid,
  input  logic [DATA_WIDTH-1:0] ustrm_data,
  input  logic                  ustrm_dvalid,
  input  logic [CRC_WIDTH-1:0]  ustrm_crc,
  input  logic                  ustrm_crc_valid,
  input  logic                  ustrm_valid,
  output logic                  ustrm_ready,
  output logic [WORD_WIDTH-1:0] txfifo_upstream_data,
  output logic                  txfifo_upstream_push,
  input  logic                  txfifo_upstream_full,
  output logic [7:0]            ustrm_drop_cnt
);

  localparam int D_LO     = 6;
  localparam int D_HI     = D_LO + DATA_WIDTH - 1;
  localparam int DV_B     = D_HI + 1;
  localparam int CRC_LO   = DV_B + 1;
  localparam int CRC_HI   = CRC_LO + CRC_WIDTH - 1;
  localparam int CV_B     = CRC_HI + 1;
  localparam int V_B      = CV_B + 1;
  localparam int UPPER_LO = D_LO + GEN1_WIDTH;

  // In gen1 mode only the lower GEN1_WIDTH data bits are meaningful; clear the rest.
  function automatic logic [WORD_WIDTH-1:0] gen_mask(input logic [WORD_WIDTH-1:0] word,
                                                     input logic gen2);
    logic [WORD_WIDTH-1:0] m;
    m = word;
    if (!gen2) begin
      m[D_HI:UPPER_LO] = {(DATA_WIDTH-GEN1_WIDTH){1'b0}};
    end else begin
      m = word;
    end
    return m;
  endfunction

  logic                  run_r;
  logic                  a_full_r;
  logic                  b_full_r;
  logic [WORD_WIDTH-1:0] b_word_r;
  logic                  pop_s;
  logic                  consume_s;
  logic                  a_from_b_s;
  logic                  load_a_s;
  logic                  load_b_s;
  logic                  a_full_next_s;
  logic                  b_full_next_s;
  logic [WORD_WIDTH-1:0] a_word_s;

  logic [3:0]            last_state_r;
  logic [1:0]            u_cnt_r;
  logic [WORD_WIDTH-1:0] u_slot0_r;
  logic [WORD_WIDTH-1:0] u_slot1_r;
  logic                  event_s;
  logic                  enq_s;
  logic                  drop_s;
  logic                  push_s;
  logic [1:0]            u_cnt_next_s;
  logic [WORD_WIDTH-1:0] u_word_s;

  // Leaves reset one clock late so nothing is popped or pushed while reset is asserted.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Downstream skid steering: slot A is the output register, slot B catches the overflow.
  always_comb begin
    pop_s         = 1'b0;
    consume_s     = 1'b0;
    a_from_b_s    = 1'b0;
    load_a_s      = 1'b0;
    load_b_s      = 1'b0;
    a_full_next_s = a_full_r;
    b_full_next_s = b_full_r;
    a_word_s      = rxfifo_downstream_data;
    pop_s         = run_r & rxfifo_downstream_vld & ~b_full_r;
    consume_s     = a_full_r & dstrm_ready;
    a_from_b_s    = consume_s & b_full_r;
    load_a_s      = a_from_b_s | (pop_s & (~a_full_r | consume_s));
    load_b_s      = pop_s & a_full_r & ~consume_s;
    a_full_next_s = load_a_s | (a_full_r & ~consume_s);
    b_full_next_s = load_b_s | (b_full_r & ~a_from_b_s);
    if (a_from_b_s) begin
      a_word_s = gen_mask(b_word_r, m_gen2_mode);
    end else begin
      a_word_s = gen_mask(rxfifo_downstream_data, m_gen2_mode);
    end
  end

  assign rxfifo_downstream_rd = pop_s;

  // Downstream skid storage and registered dstrm_* outputs.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      a_full_r        <= 1'b0;
      b_full_r        <= 1'b0;
      b_word_r        <= {WORD_WIDTH{1'b0}};
      dstrm_state     <= 4'd0;
      dstrm_protid    <= 2'd0;
      dstrm_data      <= {DATA_WIDTH{1'b0}};
      dstrm_dvalid    <= 1'b0;
      dstrm_crc       <= {CRC_WIDTH{1'b0}};
      dstrm_crc_valid <= 1'b0;
      dstrm_valid     <= 1'b0;
    end else begin
      a_full_r <= a_full_next_s;
      b_full_r <= b_full_next_s;
      if (load_b_s) begin
        b_word_r <= rxfifo_downstream_data;
      end
      if (load_a_s) begin
        dstrm_state     <= a_word_s[3:0];
        dstrm_protid    <= a_word_s[5:4];
        dstrm_data      <= a_word_s[D_HI:D_LO];
        dstrm_dvalid    <= a_word_s[DV_B];
        dstrm_crc       <= a_word_s[CRC_HI:CRC_LO];
        dstrm_crc_valid <= a_word_s[CV_B];
        dstrm_valid     <= a_word_s[V_B];
      end else if (consume_s) begin
        // Qualifiers drop with the beat; state and payload fields hold their last value.
        dstrm_dvalid    <= 1'b0;
        dstrm_crc_valid <= 1'b0;
        dstrm_valid     <= 1'b0;
      end
    end
  end

  // Upstream capture, enqueue/drop decision and skid occupancy.
  always_comb begin
    event_s      = 1'b0;
    enq_s        = 1'b0;
    drop_s       = 1'b0;
    push_s       = 1'b0;
    u_cnt_next_s = u_cnt_r;
    u_word_s     = gen_mask({ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
                             ustrm_data, ustrm_protid, ustrm_state}, m_gen2_mode);
    event_s      = run_r & (ustrm_valid | (ustrm_state != last_state_r));
    enq_s        = event_s & ustrm_ready;
    drop_s       = event_s & ~ustrm_ready;
    push_s       = (u_cnt_r != 2'd0) & ~txfifo_upstream_full;
    case ({enq_s, push_s})
      2'b10:   u_cnt_next_s = u_cnt_r + 2'd1;
      2'b01:   u_cnt_next_s = u_cnt_r - 2'd1;
      default: u_cnt_next_s = u_cnt_r;
    endcase
  end

  assign txfifo_upstream_push = push_s;
  assign txfifo_upstream_data = u_slot0_r;

  // Upstream skid storage; slot0 is always the head presented to the TX FIFO.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      u_cnt_r   <= 2'd0;
      u_slot0_r <= {WORD_WIDTH{1'b0}};
      u_slot1_r <= {WORD_WIDTH{1'b0}};
    end else begin
      u_cnt_r <= u_cnt_next_s;
      case ({enq_s, push_s})
        2'b11: begin
          if (u_cnt_r == 2'd1) begin
            u_slot0_r <= u_word_s;
          end else begin
            u_slot0_r <= u_slot1_r;
            u_slot1_r <= u_word_s;
          end
        end
        2'b01: u_slot0_r <= u_slot1_r;
        2'b10: begin
          if (u_cnt_r == 2'd0) begin
            u_slot0_r <= u_word_s;
          end else begin
            u_slot1_r <= u_word_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered ready, last-state tracker and saturating drop counter.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      ustrm_ready    <= 1'b0;
      last_state_r   <= 4'd0;
      ustrm_drop_cnt <= 8'd0;
    end else begin
      ustrm_ready <= (u_cnt_next_s != 2'd2);
      if (event_s) begin
        last_state_r <= ustrm_state;
      end
      if (drop_s && (ustrm_drop_cnt != 8'hFF)) begin
        ustrm_drop_cnt <= ustrm_drop_cnt + 8'd1;
      end
    end
  end

endmodule
